// File: rtl/calculator_core.sv
// -----------------------------------------------------------------------------
// calculator_core
//
// Four-digit BCD add/subtract calculator driven by raw buttons and sliders.
// It drives a multiplexed, active-low seven-segment display.
//
// Every raw input passes through its own debouncer. The clear and enter buttons
// act on the rising edge of their debounced level. Each slider auto-increments
// one digit of the entry register while it is held.
//
// A three-state FSM collects operand A, then operand B, then shows the result.
// The result follows the debounced add/subtract select level while it is shown.
//
// Ports
//   clk                 sole clock, rising edge
//   reset               asynchronous, active-high
//   button_clr_undeb    raw clear button
//   button_ent_undeb    raw enter button
//   slider_1_undeb      raw increment for digit 3 (leftmost)
//   slider_2_undeb      raw increment for digit 2
//   slider_3_undeb      raw increment for digit 1
//   slider_4_undeb      raw increment for digit 0 (rightmost)
//   arithmetic_select   raw operation select, 0 = add, 1 = subtract
//   digit_select[3:0]   active-low one-hot digit enable, bit0 = rightmost
//   led_select[6:0]     active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module calculator_core #(
  parameter int REFRESH_OVERFLOW = 100000,
  parameter int DB_OVERFLOW      = 1000000,
  parameter int SLIDER_OVERFLOW  = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_clr_undeb,
  input  logic       button_ent_undeb,
  input  logic       slider_1_undeb,
  input  logic       slider_2_undeb,
  input  logic       slider_3_undeb,
  input  logic       slider_4_undeb,
  input  logic       arithmetic_select,
  output logic [3:0] digit_select,
  output logic [6:0] led_select
);

  localparam int RW  = $clog2(REFRESH_OVERFLOW + 1);
  localparam int DBW = $clog2(DB_OVERFLOW + 1);
  localparam int SW  = $clog2(SLIDER_OVERFLOW + 1);

  localparam logic [RW-1:0]  RF_LAST = RW'(REFRESH_OVERFLOW);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_OVERFLOW - 1);
  localparam logic [SW-1:0]  SL_LAST = SW'(SLIDER_OVERFLOW);

  // Bit positions in the raw and debounced input vectors.
  localparam int IDX_CLR = 0;
  localparam int IDX_ENT = 1;
  localparam int IDX_D0  = 2;  // sliders occupy IDX_D0 .. IDX_D0+3, digit order
  localparam int IDX_SEL = 6;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    RESULT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Debouncers
  // ---------------------------------------------------------------------------
  logic [6:0]     raw_vec;
  logic [6:0]     db_q;
  logic [DBW-1:0] db_cnt_q [7];

  assign raw_vec = {arithmetic_select, slider_1_undeb, slider_2_undeb,
                    slider_3_undeb, slider_4_undeb, button_ent_undeb,
                    button_clr_undeb};

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples values from before the edge, whatever the order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q <= '0;
      // NOTE: small counter arrays need a known start value, so each element
      // is cleared by reset explicitly (a real RAM would not be).
      for (int i = 0; i < 7; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (raw_vec[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          // This edge is the DB_OVERFLOW-th consecutive differing sample.
          db_q[i]     <= raw_vec[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Button edge events
  // ---------------------------------------------------------------------------
  logic clr_prev_q, ent_prev_q;
  logic clr_evt, ent_evt;

  assign clr_evt = db_q[IDX_CLR] & ~clr_prev_q;
  assign ent_evt = db_q[IDX_ENT] & ~ent_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_prev_q <= 1'b0;
      ent_prev_q <= 1'b0;
    end else begin
      clr_prev_q <= db_q[IDX_CLR];
      ent_prev_q <= db_q[IDX_ENT];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   load_a, load_b, clear_all, slider_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ENTER_A;
    else       state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load_a    = 1'b0;
    load_b    = 1'b0;
    clear_all = 1'b0;
    slider_en = (state_q != RESULT);
    if (clr_evt) begin
      // Clear wins over a simultaneous enter.
      clear_all = 1'b1;
      state_d   = ENTER_A;
    end else begin
      unique case (state_q)
        ENTER_A: if (ent_evt) begin
          load_a  = 1'b1;
          state_d = ENTER_B;
        end
        ENTER_B: if (ent_evt) begin
          load_b  = 1'b1;
          state_d = RESULT;
        end
        RESULT:  state_d = RESULT;
        default: state_d = ENTER_A;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Slider auto-increment counters (index = digit position)
  // ---------------------------------------------------------------------------
  logic [3:0]    sl_db;
  logic [3:0]    sl_inc;
  logic [SW-1:0] sl_cnt_q [4];

  assign sl_db = db_q[IDX_D0 +: 4];

  always_comb begin
    for (int n = 0; n < 4; n++) sl_inc[n] = sl_db[n] && (sl_cnt_q[n] == SL_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) sl_cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (clear_all || !sl_db[n] || sl_inc[n]) sl_cnt_q[n] <= '0;
        else                                     sl_cnt_q[n] <= sl_cnt_q[n] + SW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand registers (packed BCD, [digit][bit])
  // ---------------------------------------------------------------------------
  logic [3:0][3:0] e_q, a_q, b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (clear_all) begin
      e_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (load_a) begin
      a_q <= e_q;
      e_q <= '0;
    end else begin
      if (load_b) b_q <= e_q;
      if (slider_en) begin
        // Each digit wraps 9 -> 0 on its own; there is no carry between digits.
        for (int n = 0; n < 4; n++) begin
          if (sl_inc[n]) e_q[n] <= (e_q[n] == 4'd9) ? 4'd0 : e_q[n] + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit-serial BCD add and subtract
  // ---------------------------------------------------------------------------
  logic [3:0][3:0] sum_d, diff_d;
  logic [4:0]      add_t, add_adj, sub_t, sub_adj;
  logic            add_c, sub_b;

  always_comb begin
    sum_d   = '0;
    diff_d  = '0;
    add_t   = '0;
    add_adj = '0;
    sub_t   = '0;
    sub_adj = '0;
    add_c   = 1'b0;
    sub_b   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      add_t   = {1'b0, a_q[i]} + {1'b0, b_q[i]} + {4'b0, add_c};
      add_adj = add_t - 5'd10;
      if (add_t > 5'd9) begin
        sum_d[i] = add_adj[3:0];
        add_c    = 1'b1;
      end else begin
        sum_d[i] = add_t[3:0];
        add_c    = 1'b0;
      end
      // A ten is pre-added so the digit difference never goes negative.
      sub_t   = {1'b0, a_q[i]} + 5'd10 - {1'b0, b_q[i]} - {4'b0, sub_b};
      sub_adj = sub_t - 5'd10;
      if (sub_t >= 5'd10) begin
        diff_d[i] = sub_adj[3:0];
        sub_b     = 1'b0;
      end else begin
        diff_d[i] = sub_t[3:0];
        sub_b     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display refresh and segment decode
  // ---------------------------------------------------------------------------
  logic [RW-1:0] ref_cnt_q;
  logic [1:0]    active_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt_q <= '0;
      active_q  <= 2'd0;
    end else if (ref_cnt_q == RF_LAST) begin
      ref_cnt_q <= '0;
      active_q  <= active_q + 2'd1;
    end else begin
      ref_cnt_q <= ref_cnt_q + RW'(1);
    end
  end

  logic [3:0][3:0] disp_d;
  logic            dash;
  logic [3:0]      cur_digit;
  logic [6:0]      seg_hi;

  always_comb begin
    disp_d = e_q;
    dash   = 1'b0;
    if (state_q == RESULT) begin
      // The result shows dashes on carry out (> 9999) or on final borrow (< 0).
      disp_d = db_q[IDX_SEL] ? diff_d : sum_d;
      dash   = db_q[IDX_SEL] ? sub_b  : add_c;
    end
    cur_digit = disp_d[active_q];
    unique case (cur_digit)
      4'd0:    seg_hi = 7'h3F;
      4'd1:    seg_hi = 7'h06;
      4'd2:    seg_hi = 7'h5B;
      4'd3:    seg_hi = 7'h4F;
      4'd4:    seg_hi = 7'h66;
      4'd5:    seg_hi = 7'h6D;
      4'd6:    seg_hi = 7'h7D;
      4'd7:    seg_hi = 7'h07;
      4'd8:    seg_hi = 7'h7F;
      4'd9:    seg_hi = 7'h6F;
      default: seg_hi = 7'h00;
    endcase
  end

  assign digit_select = ~(4'b0001 << active_q);
  assign led_select   = dash ? 7'b0111111 : ~seg_hi;

endmodule

// File: tb/tb_calculator_core.sv
module tb_calculator_core;

  localparam int REF_OV = 10;
  localparam int DB_OV  = 1;
  localparam int SL_OV  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       button_clr_undeb, button_ent_undeb;
  logic       slider_1_undeb, slider_2_undeb, slider_3_undeb, slider_4_undeb;
  logic       arithmetic_select;
  logic [3:0] digit_select;
  logic [6:0] led_select;

  always #5 clk = ~clk;

  calculator_core #(
    .REFRESH_OVERFLOW(REF_OV),
    .DB_OVERFLOW     (DB_OV),
    .SLIDER_OVERFLOW (SL_OV)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .button_clr_undeb (button_clr_undeb),
    .button_ent_undeb (button_ent_undeb),
    .slider_1_undeb   (slider_1_undeb),
    .slider_2_undeb   (slider_2_undeb),
    .slider_3_undeb   (slider_3_undeb),
    .slider_4_undeb   (slider_4_undeb),
    .arithmetic_select(arithmetic_select),
    .digit_select     (digit_select),
    .led_select       (led_select)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: calculator behaviour in plain decimal terms
  // ---------------------------------------------------------------------------
  int m_state;   // 0 = entering A, 1 = entering B, 2 = showing result
  int m_e [4];   // entry digits, index = digit position
  int m_a, m_b;  // stored operands as decimal integers
  bit m_sel;

  function automatic int e_value();
    return m_e[3] * 1000 + m_e[2] * 100 + m_e[1] * 10 + m_e[0];
  endfunction

  function automatic void model_clear();
    m_state = 0;
    for (int i = 0; i < 4; i++) m_e[i] = 0;
    m_a = 0;
    m_b = 0;
  endfunction

  function automatic void model_enter();
    if (m_state == 0) begin
      m_a = e_value();
      for (int i = 0; i < 4; i++) m_e[i] = 0;
      m_state = 1;
    end else if (m_state == 1) begin
      m_b = e_value();
      m_state = 2;
    end
  endfunction

  function automatic void model_bump(int dig, int n);
    if (m_state != 2) m_e[dig] = (m_e[dig] + n) % 10;
  endfunction

  function automatic logic [6:0] seg_pattern(int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Four active-low patterns, digit 3 in the top bits.
  function automatic logic [27:0] expected_display();
    int r;
    int dg [4];
    logic [27:0] v;
    if (m_state == 2) begin
      r = m_sel ? (m_a - m_b) : (m_a + m_b);
      if (r < 0 || r > 9999) return {4{7'b0111111}};
      dg[0] = r % 10;
      dg[1] = (r / 10) % 10;
      dg[2] = (r / 100) % 10;
      dg[3] = (r / 1000) % 10;
    end else begin
      for (int i = 0; i < 4; i++) dg[i] = m_e[i];
    end
    v = '0;
    for (int i = 0; i < 4; i++) v[i*7 +: 7] = ~seg_pattern(dg[i]);
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change and outputs are sampled on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sliders(input logic [3:0] v);
    slider_4_undeb = v[0];
    slider_3_undeb = v[1];
    slider_2_undeb = v[2];
    slider_1_undeb = v[3];
  endtask

  // All four sliders are driven at once; each is held for just long enough to
  // add its decimal digit of v to the matching entry digit.
  task automatic enter_value(input int v);
    int d [4];
    logic [3:0] s;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = (v / 1000) % 10;
    for (int t = 0; t < 9 * (SL_OV + 1); t++) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) s[n] = (t < d[n] * (SL_OV + 1));
      set_sliders(s);
    end
    @(negedge clk);
    set_sliders(4'b0);
    idle(3);
    for (int n = 0; n < 4; n++) model_bump(n, d[n]);
  endtask

  task automatic hold_slider(input int dig, input int cycles);
    logic [3:0] s;
    s = 4'b0;
    s[dig] = 1'b1;
    @(negedge clk);
    set_sliders(s);
    idle(cycles);
    set_sliders(4'b0);
    idle(3);
    model_bump(dig, cycles / (SL_OV + 1));
  endtask

  task automatic press(input bit c, input bit e, input int hold);
    @(negedge clk);
    button_clr_undeb = c;
    button_ent_undeb = e;
    idle(hold);
    button_clr_undeb = 1'b0;
    button_ent_undeb = 1'b0;
    idle(3);
    if (c) model_clear();
    else if (e) model_enter();
  endtask

  task automatic set_sel(input bit s);
    @(negedge clk);
    arithmetic_select = s;
    m_sel = s;
    idle(3);
  endtask

  task automatic read_display(input string tag);
    logic [6:0] got [4];
    logic [3:0] seen;
    int bad;
    seen = 4'b0;
    bad  = 0;
    for (int i = 0; i < 4; i++) got[i] = 7'h00;
    for (int c = 0; c < 8 * (REF_OV + 1) && seen != 4'hF; c++) begin
      @(negedge clk);
      case (digit_select)
        4'b1110: begin got[0] = led_select; seen[0] = 1'b1; end
        4'b1101: begin got[1] = led_select; seen[1] = 1'b1; end
        4'b1011: begin got[2] = led_select; seen[2] = 1'b1; end
        4'b0111: begin got[3] = led_select; seen[3] = 1'b1; end
        default: bad++;
      endcase
    end
    check($sformatf("%s_dsel_onehot", tag), bad, 0);
    check($sformatf("%s_all_digits", tag), seen, 4'hF);
    check(tag, {got[3], got[2], got[1], got[0]}, expected_display());
  endtask

  task automatic run_calc(input string tag, input int a, input int b, input bit s);
    press(1'b1, 1'b0, 1);
    enter_value(a);
    press(1'b0, 1'b1, 1);
    enter_value(b);
    press(1'b0, 1'b1, 1);
    set_sel(s);
    read_display($sformatf("%s_sel%0d", tag, s));
    set_sel(!s);
    read_display($sformatf("%s_sel%0d", tag, !s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev;
    int c;
    int a, b;

    reset = 1'b0;
    button_clr_undeb = 1'b0;
    button_ent_undeb = 1'b0;
    set_sliders(4'b0);
    arithmetic_select = 1'b0;
    m_sel = 1'b0;
    model_clear();

    #2 reset = 1'b1;
    #1;
    check("rst_dsel", digit_select, 4'b1110);
    check("rst_led", led_select, 7'b1000000);
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_dsel", digit_select, 4'b1110);
    check("post_rst_led", led_select, 7'b1000000);

    // Slider on digit 0 for 7 cycles, then the digit scan cadence.
    hold_slider(0, 7);
    prev = digit_select;
    c = 0;
    while (digit_select == prev && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("walk_sync", (c < 40), 1);
    for (int k = 0; k < 4; k++) begin
      prev = digit_select;
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (digit_select == prev && c < 40);
      check($sformatf("walk_step%0d", k), c, REF_OV + 1);
      check($sformatf("walk_dir%0d", k), digit_select, {prev[2:0], prev[3]});
    end
    read_display("slider4_x3");

    // Directed operands.
    run_calc("a1203_b0045", 1203, 45, 1'b0);
    enter_value(1111);
    read_display("result_ignores_sliders");
    press(1'b0, 1'b1, 1);
    read_display("result_ignores_ent");
    run_calc("a0005_b0010", 5, 10, 1'b1);
    run_calc("a9999_b0001", 9999, 1, 1'b0);
    run_calc("a9999_b9999", 9999, 9999, 1'b1);

    // Digit 1 wraps after ten increments; digit 2 is left alone.
    press(1'b1, 1'b0, 1);
    enter_value(400);
    hold_slider(1, 21);
    read_display("slider3_wrap");

    // A long enter press makes exactly one transition.
    press(1'b1, 1'b0, 1);
    enter_value(37);
    press(1'b0, 1'b1, 5);
    read_display("long_ent_once");
    enter_value(12);
    press(1'b0, 1'b1, 1);
    read_display("long_ent_result");

    // Clear from RESULT, then a fresh calculation.
    press(1'b1, 1'b0, 1);
    read_display("clr_in_result");
    enter_value(77);
    press(1'b0, 1'b1, 1);
    read_display("after_clr_a_stored");
    enter_value(3);
    press(1'b0, 1'b1, 1);
    read_display("after_clr_result");

    // Reset in the middle of entering B.
    press(1'b1, 1'b0, 1);
    enter_value(55);
    press(1'b0, 1'b1, 1);
    enter_value(66);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midb_rst_dsel", digit_select, 4'b1110);
    check("midb_rst_led", led_select, 7'b1000000);
    idle(2);
    reset = 1'b0;
    model_clear();
    idle(2);
    read_display("midb_rst_zero");
    enter_value(8);
    press(1'b0, 1'b1, 1);
    enter_value(2);
    press(1'b0, 1'b1, 1);
    read_display("midb_rst_result");

    // Clear and enter together: clear wins.
    press(1'b1, 1'b0, 1);
    enter_value(4);
    press(1'b0, 1'b1, 1);
    enter_value(5);
    press(1'b1, 1'b1, 1);
    read_display("clr_ent_same");
    enter_value(6);
    press(1'b0, 1'b1, 1);
    enter_value(7);
    press(1'b0, 1'b1, 1);
    read_display("clr_ent_result");

    // Random operands.
    for (int it = 0; it < 8; it++) begin
      a = $urandom_range(0, 9999);
      b = $urandom_range(0, 9999);
      run_calc($sformatf("rnd%0d", it), a, b, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/calculator_core.md
CALCULATOR_CORE -- requirements
Module: calculator

Interface
REQ-001 SHALL have parameter REFRESH_OVERFLOW, default 100000, cycles per display digit slot minus one.
REQ-002 SHALL have parameter DB_OVERFLOW, default 1000000, number of consecutive differing samples needed to accept a new input level.
REQ-003 SHALL have parameter SLIDER_OVERFLOW, default 25000000, auto-increment period minus one, in cycles.
REQ-004 SHALL have the following ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high.
- button_clr_undeb  input  1  raw clear button.
- button_ent_undeb  input  1  raw enter button.
- slider_1_undeb..slider_4_undeb  input  1 each  raw digit-increment sliders; slider_1 = digit 3 (leftmost) ... slider_4 = digit 0 (rightmost).
- arithmetic_select  input  1  raw operation select; 0 = add, 1 = subtract.
- digit_select  output  4  active-low one-hot digit enable; bit0 = rightmost digit.
- led_select  output  7  active-low segments {g,f,e,d,c,b,a}; bit0 = a.

Function
REQ-005 SHALL pass every raw input through its own debouncer; the debounced level takes the raw level on the edge where raw has differed from it for DB_OVERFLOW consecutive edges; any agreeing sample zeroes the counter.
REQ-006 SHALL treat clr/ent as a single-cycle event on the rising edge of the debounced level; holding a button SHALL produce no repeat.
REQ-007 SHALL hold a 4-digit BCD entry register E (digits 0-9 each).
REQ-008 While debounced slider_n is high, SHALL run a per-slider counter 0..SLIDER_OVERFLOW; on the edge it equals SLIDER_OVERFLOW, increment digit n of E modulo 10 (9 -> 0, no carry) and restart at 0; slider low SHALL zero its counter.
REQ-009 Sliders SHALL act independently; several high at once increment their digits in the same cycle.
REQ-010 SHALL implement FSM states ENTER_A (reset state), ENTER_B, RESULT.
REQ-011 ENTER_A: display E; ent event -> A <= E, E <= 0, go ENTER_B.
REQ-012 ENTER_B: display E; ent event -> B <= E, go RESULT.
REQ-013 RESULT: sliders and ent ignored; display R = A+B (select 0) or A-B (select 1), following the debounced select level live.
REQ-014 If R > 9999 or R < 0, SHALL display four dashes (segment g only, led_select = 7'b0111111); otherwise R as 4 decimal digits with leading zeros.
REQ-015 A clr event in any state SHALL zero E, A, B, all slider counters and go to ENTER_A; clr coinciding with ent SHALL let clr win.
REQ-016 SHALL multiplex the display: refresh counter 0..REFRESH_OVERFLOW; on the edge it equals REFRESH_OVERFLOW, wrap to 0 and advance the active digit 0->1->2->3->0.
REQ-017 digit_select SHALL be low only at the active digit position; led_select SHALL be the active-low segment pattern of that digit's value, derived combinationally from registered state.
REQ-018 Decimal patterns (active-high gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; outputs SHALL be their bitwise inverse.

Reset
REQ-019 Asserted reset SHALL immediately force state ENTER_A; E, A, B, all counters, debounced levels = 0; active digit 0.
REQ-020 During and right after reset, digit_select SHALL be 4'b1110 and led_select SHALL be 7'b1000000 ("0").
REQ-021 Reset asserted mid-entry or in RESULT SHALL discard all operands with no residual event.

Verification (REFRESH_OVERFLOW=10, DB_OVERFLOW=1, SLIDER_OVERFLOW=1)
REQ-022 Release reset, hold slider_4 high for 7 cycles -> digit 0 shows 3, other digits 0; digit_select walks 1110,1101,1011,0111 with a step every 11 cycles.
REQ-023 Enter A=1203 (slider_1 x1, slider_2 x2, slider_4 x3), pulse ent 1 cycle; enter B=0045, pulse ent, select=0 -> display 1248; set select=1 -> display 1158.
REQ-024 A=0005, B=0010, select=1 -> display four dashes; A=9999, B=0001, select=0 -> four dashes.
REQ-025 Hold slider_3 for 21 cycles from 0 -> digit 1 wraps to 0 after 10 increments, digit 2 unchanged.
REQ-026 Pulse clr in RESULT, and separately assert reset mid-ENTER_B -> display 0000, next ent stores A.
REQ-027 Raw ent held 5 cycles -> exactly one state transition.
